// File: rtl/uart_prog_loader.sv
// UART boot loader: receives a framed program image (A5, N, N x {hi,lo}, sum)
// over an 8N1 line, writes it into instruction memory and gates the CPU reset.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CLKS = 65535,
  parameter bit          BOOT_HOLD    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [15:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned BCW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF   = CLKS_PER_BIT / 2;
  localparam int unsigned TOW    = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned WCW    = 9;
  localparam int unsigned MAXW   = (ADDR_WIDTH >= 8) ? 256 : (1 << ADDR_WIDTH);
  localparam logic [7:0]  HEADER = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [2:0] {L_IDLE, L_COUNT, L_HI, L_LO, L_CSUM} ld_state_e;

  // ---------------------------------------------------------------------------
  // rx synchronizer plus one extra stage for falling-edge detection
  // ---------------------------------------------------------------------------
  logic sync1_q, rx_s_q, rx_prev_q;

  // Two-flop synchronizer and edge-history flop, idle-high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // ---------------------------------------------------------------------------
  // UART byte receiver
  // ---------------------------------------------------------------------------
  rx_state_e        rx_st_q, rx_st_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [2:0]       bidx_q, bidx_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ferr_q, rx_ferr_d;

  // Receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q    <= R_IDLE;
      bcnt_q     <= '0;
      bidx_q     <= '0;
      shift_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_st_q    <= rx_st_d;
      bcnt_q     <= bcnt_d;
      bidx_q     <= bidx_d;
      shift_q    <= shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // Receiver next state: start re-check at half bit, then sample bit centres
  always_comb begin
    rx_st_d    = rx_st_q;
    bcnt_d     = bcnt_q;
    bidx_d     = bidx_q;
    shift_d    = shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_st_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          rx_st_d = R_START;
          bcnt_d  = '0;
        end
      end
      R_START: begin
        if (bcnt_q == BCW'(HALF - 1)) begin
          bcnt_d = '0;
          bidx_d = '0;
          // A line that is high again at mid-start was only a glitch
          rx_st_d = rx_s_q ? R_IDLE : R_DATA;
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
      R_DATA: begin
        if (bcnt_q == BCW'(CLKS_PER_BIT - 1)) begin
          bcnt_d  = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bidx_q == 3'd7) begin
            rx_st_d = R_STOP;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
      R_STOP: begin
        if (bcnt_q == BCW'(CLKS_PER_BIT - 1)) begin
          bcnt_d     = '0;
          rx_valid_d = rx_s_q;
          rx_ferr_d  = !rx_s_q;
          rx_st_d    = R_IDLE;
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame loader
  // ---------------------------------------------------------------------------
  ld_state_e             st_q, st_d;
  logic [WCW-1:0]        words_q, words_d;
  logic [7:0]            sum_q, sum_d;
  logic [TOW-1:0]        to_q, to_d;
  logic                  release_q, release_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  timeout_c;
  logic [WCW-1:0]        n_words_c;

  // Loader state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= L_IDLE;
      words_q   <= '0;
      sum_q     <= '0;
      to_q      <= '0;
      release_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hold_q    <= BOOT_HOLD;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      words_q   <= words_d;
      sum_q     <= sum_d;
      to_q      <= to_d;
      release_q <= release_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Loader next state: frame parsing, write strobe, timeout and abort
  always_comb begin
    st_d      = st_q;
    words_d   = words_q;
    sum_d     = sum_q;
    to_d      = to_q;
    release_d = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    timeout_c = 1'b0;

    // N=0 encodes 256 words; never more words than the address space holds
    n_words_c = (shift_q == 8'd0) ? WCW'(256) : WCW'(shift_q);
    if (n_words_c > WCW'(MAXW)) begin
      n_words_c = WCW'(MAXW);
    end

    // Address steps the cycle after each write pulse
    if (we_q) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
    end
    // CPU is released one cycle after done is raised
    if (release_q) begin
      hold_d = 1'b0;
    end

    // Inter-byte idle counter, only while a frame is in progress
    if ((st_q == L_IDLE) || rx_valid_q) begin
      to_d = '0;
    end else if (to_q == TOW'(TIMEOUT_CLKS - 1)) begin
      to_d      = '0;
      timeout_c = 1'b1;
    end else begin
      to_d = to_q + TOW'(1);
    end

    case (st_q)
      L_IDLE: begin
        if (rx_valid_q && (shift_q == HEADER)) begin
          st_d    = L_COUNT;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      L_COUNT: begin
        if (rx_valid_q) begin
          words_d = n_words_c;
          sum_d   = '0;
          addr_d  = '0;
          st_d    = L_HI;
        end
      end
      L_HI: begin
        if (rx_valid_q) begin
          wdata_d[15:8] = shift_q;
          sum_d         = sum_q + shift_q;
          st_d          = L_LO;
        end
      end
      L_LO: begin
        if (rx_valid_q) begin
          wdata_d[7:0] = shift_q;
          sum_d        = sum_q + shift_q;
          we_d         = 1'b1;
          words_d      = words_q - WCW'(1);
          st_d         = (words_q == WCW'(1)) ? L_CSUM : L_HI;
        end
      end
      L_CSUM: begin
        if (rx_valid_q) begin
          busy_d = 1'b0;
          st_d   = L_IDLE;
          if (shift_q == sum_q) begin
            done_d    = 1'b1;
            release_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: st_d = L_IDLE;
    endcase

    // Framing error or timeout mid-frame overrides everything, including a write
    if ((st_q != L_IDLE) && (rx_ferr_q || timeout_c)) begin
      st_d      = L_IDLE;
      error_d   = 1'b1;
      busy_d    = 1'b0;
      hold_d    = 1'b1;
      we_d      = 1'b0;
      release_d = 1'b0;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed frames, scoreboarded memory writes.
module tb_uart_prog_loader;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 8;
  localparam int unsigned TO  = 200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .TIMEOUT_CLKS(TO),
    .BOOT_HOLD   (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t        wr_q[$];
  wr_t        mon_e;
  logic [7:0] txq[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
  endtask

  // One 8N1 byte, driven on falling edges; stop_ok=0 forces a framing error
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk) rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) rx = stop_ok;
    repeat (CPB - 1) @(negedge clk);
    @(negedge clk) rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_txq();
    while (txq.size() != 0) send_byte(txq.pop_front(), 1'b1);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic h, input logic b);
    chk($sformatf("%s_done", tag), done, d);
    chk($sformatf("%s_error", tag), error, e);
    chk($sformatf("%s_hold", tag), cpu_hold, h);
    chk($sformatf("%s_busy", tag), busy, b);
  endtask

  task automatic check_reset(input string tag);
    chk($sformatf("%s_we", tag), imem_we, 0);
    chk($sformatf("%s_addr", tag), imem_addr, 0);
    chk($sformatf("%s_wdata", tag), imem_wdata, 0);
    check_status(tag, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: pops expected writes, checks pulse width and the hold release
  logic prev_we = 1'b0;
  logic prev_done = 1'b0;
  logic chk_hold_next = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we       = 1'b0;
      prev_done     = 1'b0;
      chk_hold_next = 1'b0;
    end else begin
      if (chk_hold_next) begin
        chk("hold_low_after_done", cpu_hold, 0);
        chk_hold_next = 1'b0;
      end
      if (done && !prev_done) begin
        chk("hold_high_at_done_rise", cpu_hold, 1);
        chk_hold_next = 1'b1;
      end
      if (imem_we) begin
        chk("we_one_cycle", prev_we, 0);
        chk("wr_expected", (wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          mon_e = wr_q.pop_front();
          chk("wr_addr", imem_addr, mon_e.addr);
          chk("wr_data", imem_wdata, mon_e.data);
        end
      end
      prev_we   = imem_we;
      prev_done = done;
    end
  end

  logic [7:0] sum;
  logic [7:0] hi;
  logic [7:0] lo;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single word
    exp_wr(8'h00, 16'h1234);
    txq = {8'hA5, 8'h01, 8'h12, 8'h34, 8'h46};
    send_txq();
    repeat (6) @(negedge clk);
    check_status("one", 1'b1, 1'b0, 1'b0, 1'b0);

    // Three words
    exp_wr(8'h00, 16'h0001);
    exp_wr(8'h01, 16'h0002);
    exp_wr(8'h02, 16'hABCD);
    txq = {8'hA5, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'hAB, 8'hCD, 8'h7B};
    send_txq();
    repeat (6) @(negedge clk);
    check_status("three", 1'b1, 1'b0, 1'b0, 1'b0);

    // Bad checksum: write happens, frame fails
    exp_wr(8'h00, 16'h1234);
    txq = {8'hA5, 8'h01, 8'h12, 8'h34, 8'h00};
    send_txq();
    repeat (6) @(negedge clk);
    check_status("badsum", 1'b0, 1'b1, 1'b1, 1'b0);

    // Framing error on third byte, then a good frame
    txq = {8'hA5, 8'h01};
    send_txq();
    send_byte(8'h12, 1'b0);
    repeat (4) @(negedge clk);
    check_status("ferr", 1'b0, 1'b1, 1'b1, 1'b0);
    exp_wr(8'h00, 16'h0005);
    txq = {8'hA5, 8'h01, 8'h00, 8'h05, 8'h05};
    send_txq();
    repeat (6) @(negedge clk);
    check_status("after_ferr", 1'b1, 1'b0, 1'b0, 1'b0);

    // One-cycle glitch in idle produces nothing
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (20) @(negedge clk);
    check_status("glitch", 1'b1, 1'b0, 1'b0, 1'b0);

    // Noise bytes before header are ignored
    txq = {8'h00, 8'hFF};
    send_txq();
    repeat (4) @(negedge clk);
    check_status("noise", 1'b1, 1'b0, 1'b0, 1'b0);
    exp_wr(8'h00, 16'h0007);
    txq = {8'hA5, 8'h01, 8'h00, 8'h07, 8'h07};
    send_txq();
    repeat (6) @(negedge clk);
    check_status("after_noise", 1'b1, 1'b0, 1'b0, 1'b0);

    // Timeout after one of two words; header re-asserts hold
    exp_wr(8'h00, 16'h1122);
    txq = {8'hA5};
    send_txq();
    check_status("reload", 1'b0, 1'b0, 1'b1, 1'b1);
    txq = {8'h02, 8'h11, 8'h22};
    send_txq();
    repeat (TO - 20) @(negedge clk);
    check_status("pre_timeout", 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    check_status("timeout", 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset mid-frame
    txq = {8'hA5, 8'h01, 8'h12};
    send_txq();
    chk("midframe_busy", busy, 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // N=0: 256 words, address wraps back to 0
    sum = 8'h00;
    txq = {8'hA5, 8'h00};
    for (int i = 0; i < 256; i++) begin
      hi = 8'(i);
      lo = 8'(i * 7 + 3);
      sum = sum + hi + lo;
      txq.push_back(hi);
      txq.push_back(lo);
      exp_wr(8'(i), {hi, lo});
    end
    txq.push_back(sum);
    send_txq();
    repeat (6) @(negedge clk);
    check_status("n256", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("n256_addr_wrap", imem_addr, 0);

    chk("wr_queue_drained", wr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
